dbg_halt_unit: RTL and testbench

DBG_HALT_UNIT -- requirements
Module: dbg_halt_unit

---
 rtl/dbg_halt_unit_pkg.sv | 32 +++
 rtl/dbg_halt_unit_if.sv | 48 ++++
 rtl/dbg_halt_unit_key_debounce.sv | 60 ++++++
 rtl/dbg_halt_unit.sv | 181 ++++++++++++++++++
 tb/tb_dbg_halt_unit.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_halt_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_halt_unit_pkg
//  Description : Shared CPU debug definitions: halt-unit state encoding,
//                halt-cause codes and a helper for the breakpoint index width.
//  Ports       : (package, no ports)
//  Revision    : 1.0 - initial release
// ============================================================================
package dbg_halt_unit_pkg;

    // Debug halt unit control states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } dbg_state_e;

    typedef logic [2:0] halt_cause_t;

    localparam halt_cause_t c_CAUSE_NONE       = 3'd0;
    localparam halt_cause_t c_CAUSE_DEBUG_INSN = 3'd1;
    localparam halt_cause_t c_CAUSE_BREAKPOINT = 3'd2;
    localparam halt_cause_t c_CAUSE_STEP       = 3'd3;
    localparam halt_cause_t c_CAUSE_EXTERNAL   = 3'd4;

    // Width of the breakpoint slot index; a single slot still gets one bit
    function automatic int bp_idx_width(input int num_bp);
        return (num_bp > 1) ? $clog2(num_bp) : 1;
    endfunction

endpackage : dbg_halt_unit_pkg
`default_nettype wire

// File: rtl/dbg_halt_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_halt_unit_if
//  Description : Core <-> debug halt unit signal bundle.
//  Ports       : master - core side: drives pc, is_debug, continue_key,
//                         step_mode and the breakpoint write port; receives
//                         stall, halted, halt_cause, halt_pc.
//                slave  - halt unit side (mirror of master).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dbg_halt_unit_if
    import dbg_halt_unit_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NUM_BP = 4
);
    localparam int c_IDX_W = bp_idx_width(NUM_BP);

    // Core / debugger inputs to the halt unit
    logic [XLEN-1:0]    pc;
    logic               is_debug;
    logic               continue_key;
    logic               step_mode;
    logic               bp_wr_en;
    logic [c_IDX_W-1:0] bp_idx;
    logic [XLEN-1:0]    bp_addr;
    logic               bp_en;

    // Halt unit outputs
    logic               stall;
    logic               halted;
    logic [2:0]         halt_cause;
    logic [XLEN-1:0]    halt_pc;

    modport master (
        output pc, is_debug, continue_key, step_mode,
        output bp_wr_en, bp_idx, bp_addr, bp_en,
        input  stall, halted, halt_cause, halt_pc
    );

    modport slave (
        input  pc, is_debug, continue_key, step_mode,
        input  bp_wr_en, bp_idx, bp_addr, bp_en,
        output stall, halted, halt_cause, halt_pc
    );

endinterface : dbg_halt_unit_if
`default_nettype wire

// File: rtl/dbg_halt_unit_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Push-button debouncer. The debounced level follows the raw
//                key once it has differed from the level for DEBOUNCE_CYCLES
//                consecutive cycles; any bounce back restarts the count.
//                o_press pulses for one cycle on a debounced 0->1 change.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                i_key      - raw key (assumed already in the clk domain)
//                o_level    - debounced key level
//                o_press    - one-cycle press pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key,
    output logic      o_level,
    output logic      o_press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_level;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_differs;
    logic               w_settled;

    assign w_differs = (i_key != r_level);
    // The current sample is the DEBOUNCE_CYCLES-th consecutive differing one
    assign w_settled = w_differs && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_press <= 1'b0;
            if (w_settled) begin
                r_level <= i_key;
                r_press <= i_key;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule : key_debounce
`default_nettype wire

// File: rtl/dbg_halt_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_halt_unit
//  Description : CPU debug halt controller. Halts the core on a PC breakpoint,
//                a debug-halt instruction or an external continue-key press;
//                resumes or single-steps on a debounced key press.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - dbg_halt_unit_if.slave:
//                  in : pc, is_debug, continue_key, step_mode,
//                       bp_wr_en, bp_idx, bp_addr, bp_en
//                  out: stall, halted, halt_cause, halt_pc
//  Revision    : 1.0 - initial release
// ============================================================================
module dbg_halt_unit
    import dbg_halt_unit_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int NUM_BP          = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dbg_halt_unit_if.slave bus
);

    localparam int              c_IDX_W  = bp_idx_width(NUM_BP);
    localparam logic [XLEN-1:0] c_PC_INC = XLEN'(4);

    // ------------------------------------------------------------------
    // Continue-key debouncer
    // ------------------------------------------------------------------
    logic w_key_level;
    logic w_press;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_key   (bus.continue_key),
        .o_level (w_key_level),
        .o_press (w_press)
    );

    // ------------------------------------------------------------------
    // Breakpoint table: one slot plus comparator per breakpoint. Only
    // word-address bits are stored and compared.
    // ------------------------------------------------------------------
    logic [NUM_BP-1:0] w_bp_match;

    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
        logic [XLEN-1:2] r_addr;
        logic            r_en;
        logic            w_sel;

        // Out-of-range indices never select a slot
        assign w_sel = bus.bp_wr_en && (bus.bp_idx == c_IDX_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_addr <= '0;
                r_en   <= 1'b0;
            end else if (w_sel) begin
                r_addr <= bus.bp_addr[XLEN-1:2];
                r_en   <= bus.bp_en;
            end
        end

        // Registered slot contents: a write only affects later cycles
        assign w_bp_match[gi] = r_en && (r_addr == bus.pc[XLEN-1:2]);
    end : g_bp

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    dbg_state_e      r_state;
    dbg_state_e      w_state_nxt;
    halt_cause_t     r_cause;
    halt_cause_t     w_cause_nxt;
    logic [XLEN-1:0] r_halt_pc;
    logic [XLEN-1:0] w_halt_pc_nxt;
    logic            r_skip;
    logic            w_skip_nxt;
    logic            w_bp_hit;
    logic            w_stall;
    logic            w_leave_halt;

    // The skip flag masks the breakpoint we just resumed from so that the
    // instruction under it executes once instead of re-halting immediately.
    assign w_bp_hit = (|w_bp_match) && !r_skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_cause   <= c_CAUSE_NONE;
            r_halt_pc <= '0;
            r_skip    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
            r_halt_pc <= w_halt_pc_nxt;
            r_skip    <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cause_nxt   = r_cause;
        w_halt_pc_nxt = r_halt_pc;
        w_stall       = 1'b0;
        w_leave_halt  = 1'b0;

        case (r_state)
            ST_RUN: begin
                // A breakpointed instruction is frozen in the same cycle
                w_stall = w_bp_hit;
                if (w_bp_hit) begin
                    w_state_nxt   = ST_HALTED;
                    w_cause_nxt   = c_CAUSE_BREAKPOINT;
                    w_halt_pc_nxt = bus.pc;
                end else if (bus.is_debug) begin
                    // Debug instruction retires; its own PC is reported
                    w_state_nxt   = ST_HALTED;
                    w_cause_nxt   = c_CAUSE_DEBUG_INSN;
                    w_halt_pc_nxt = bus.pc;
                end else if (w_press) begin
                    // Current instruction retires; resume at the next one
                    w_state_nxt   = ST_HALTED;
                    w_cause_nxt   = c_CAUSE_EXTERNAL;
                    w_halt_pc_nxt = bus.pc + c_PC_INC;
                end
            end

            ST_HALTED: begin
                w_stall = 1'b1;
                if (w_press) begin
                    w_leave_halt = 1'b1;
                    w_state_nxt  = bus.step_mode ? ST_STEP : ST_RUN;
                    w_cause_nxt  = c_CAUSE_NONE;
                end
            end

            ST_STEP: begin
                // One unstalled cycle, then always back to HALTED
                w_state_nxt = ST_HALTED;
                if (w_bp_hit) begin
                    w_cause_nxt   = c_CAUSE_BREAKPOINT;
                    w_halt_pc_nxt = bus.pc;
                end else if (bus.is_debug) begin
                    w_cause_nxt   = c_CAUSE_DEBUG_INSN;
                    w_halt_pc_nxt = bus.pc;
                end else begin
                    w_cause_nxt   = c_CAUSE_STEP;
                    w_halt_pc_nxt = bus.pc + c_PC_INC;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        w_skip_nxt = r_skip;
        if (w_leave_halt && (r_cause == c_CAUSE_BREAKPOINT)) begin
            w_skip_nxt = 1'b1;
        end else if (!w_stall) begin
            w_skip_nxt = 1'b0;
        end
    end

    assign bus.stall      = w_stall;
    assign bus.halted     = (r_state == ST_HALTED);
    assign bus.halt_cause = r_cause;
    assign bus.halt_pc    = r_halt_pc;

    // Byte-offset bits and the debounced level are intentionally unused
    logic w_unused;
    assign w_unused = &{1'b0, w_key_level, bus.pc[1:0], bus.bp_addr[1:0]};

endmodule : dbg_halt_unit
`default_nettype wire

// File: tb/tb_dbg_halt_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbg_halt_unit
//  Description : Self-checking bench for dbg_halt_unit: directed scenarios
//                plus randomized traffic compared with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_halt_unit;

    localparam int XLEN   = 64;
    localparam int NUM_BP = 3;
    localparam int DEB    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dbg_halt_unit_if #(.XLEN(XLEN), .NUM_BP(NUM_BP)) bus ();

    dbg_halt_unit #(
        .XLEN            (XLEN),
        .NUM_BP          (NUM_BP),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    // m_mode: 0 running, 1 halted, 2 single-stepping
    int          m_mode    = 0;
    logic [2:0]  m_cause   = 3'd0;
    logic [63:0] m_hpc     = 64'd0;
    bit          m_skip    = 1'b0;
    logic [63:0] m_bpa [NUM_BP];
    bit          m_bpe [NUM_BP];
    bit          m_level   = 1'b0;
    bit          m_run_key = 1'b0;
    int          m_run_len = 0;
    bit          m_press   = 1'b0;

    function automatic bit m_hit();
        bit h = 1'b0;
        for (int i = 0; i < NUM_BP; i++)
            if (m_bpe[i] && (m_bpa[i][63:2] == bus.pc[63:2])) h = 1'b1;
        return h && !m_skip;
    endfunction

    function automatic bit m_stall();
        return (m_mode == 1) || ((m_mode == 0) && m_hit());
    endfunction

    task automatic model_update();
        bit hit, st, pr, leave;
        if (rst) begin
            m_mode = 0; m_cause = 3'd0; m_hpc = 64'd0; m_skip = 1'b0;
            for (int i = 0; i < NUM_BP; i++) m_bpe[i] = 1'b0;
            m_level = 1'b0; m_run_key = 1'b0; m_run_len = 0; m_press = 1'b0;
            return;
        end
        hit = m_hit(); st = m_stall(); pr = m_press; leave = 1'b0;
        if (m_mode == 0) begin
            if (hit)               begin m_mode = 1; m_cause = 3'd2; m_hpc = bus.pc; end
            else if (bus.is_debug) begin m_mode = 1; m_cause = 3'd1; m_hpc = bus.pc; end
            else if (pr)           begin m_mode = 1; m_cause = 3'd4; m_hpc = bus.pc + 64'd4; end
        end else if (m_mode == 1) begin
            leave = pr;
        end else begin
            m_mode = 1;
            if (hit)               begin m_cause = 3'd2; m_hpc = bus.pc; end
            else if (bus.is_debug) begin m_cause = 3'd1; m_hpc = bus.pc; end
            else                   begin m_cause = 3'd3; m_hpc = bus.pc + 64'd4; end
        end
        if (leave) begin
            m_skip  = (m_cause == 3'd2);
            m_mode  = bus.step_mode ? 2 : 0;
            m_cause = 3'd0;
        end else if (!st) begin
            m_skip = 1'b0;
        end
        // Debounce: level flips once the key has held a new value for DEB samples
        if (bus.continue_key == m_run_key) m_run_len++;
        else begin m_run_key = bus.continue_key; m_run_len = 1; end
        m_press = 1'b0;
        if ((m_run_key != m_level) && (m_run_len >= DEB)) begin
            m_level = m_run_key;
            m_press = m_run_key;
        end
        if (bus.bp_wr_en && (int'(bus.bp_idx) < NUM_BP)) begin
            m_bpa[bus.bp_idx] = bus.bp_addr;
            m_bpe[bus.bp_idx] = bus.bp_en;
        end
    endtask

    // ---------------- stimulus utilities ----------------
    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
    endtask

    // Holds the key for DEB cycles; on return the press pulse is live this cycle
    task automatic press_pulse();
        bus.continue_key = 1'b1;
        repeat (DEB) adv();
        bus.continue_key = 1'b0;
    endtask

    task automatic release_wait();
        bus.continue_key = 1'b0;
        repeat (DEB) adv();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) adv();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.halted !== 1'b0 || bus.halt_cause !== 3'd0 || bus.halt_pc !== 64'd0) begin
            n_bad++;
            $display("FAIL reset: stall=%b halted=%b cause=%0d hpc=%h, want 0/0/0/0",
                     bus.stall, bus.halted, bus.halt_cause, bus.halt_pc);
        end
        adv();
    endtask

    task automatic test_breakpoint();
        bus.bp_wr_en = 1'b1; bus.bp_idx = 2'd1; bus.bp_addr = 64'h40; bus.bp_en = 1'b1;
        bus.pc = 64'h30;
        adv();
        bus.bp_wr_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.pc = 64'h38 + 64'(4 * k);
            @(negedge clk);
            n_cmp++;
            if (bus.stall !== 1'b0) begin
                n_bad++; $display("FAIL bp_pre_stall pc=%h: got %b want 0", bus.pc, bus.stall);
            end
            adv();
        end
        bus.pc = 64'h40;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b1 || bus.halted !== 1'b0) begin
            n_bad++; $display("FAIL bp_hit_stall: stall=%b halted=%b want 1/0", bus.stall, bus.halted);
        end
        adv();
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.halt_cause !== 3'd2 || bus.halt_pc !== 64'h40 || bus.stall !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_halt: halted=%b cause=%0d hpc=%h stall=%b want 1/2/40/1",
                     bus.halted, bus.halt_cause, bus.halt_pc, bus.stall);
        end
        adv();
    endtask

    task automatic test_resume_skip();
        bus.step_mode = 1'b0;
        press_pulse();
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b1) begin
            n_bad++; $display("FAIL resume_press_cycle: halted=%b want 1", bus.halted);
        end
        adv();
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.halted !== 1'b0 || bus.halt_cause !== 3'd0) begin
            n_bad++;
            $display("FAIL resume_exec_bp: stall=%b halted=%b cause=%0d want 0/0/0",
                     bus.stall, bus.halted, bus.halt_cause);
        end
        adv();
        for (int k = 0; k < 3; k++) begin
            bus.pc = 64'h44 + 64'(4 * k);
            @(negedge clk);
            n_cmp++;
            if (bus.stall !== 1'b0 || bus.halted !== 1'b0) begin
                n_bad++; $display("FAIL resume_continue pc=%h: stall=%b halted=%b want 0/0",
                                  bus.pc, bus.stall, bus.halted);
            end
            adv();
        end
        release_wait();
    endtask

    task automatic test_debug_step();
        bus.pc = 64'h100; bus.is_debug = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.halted !== 1'b0) begin
            n_bad++; $display("FAIL dbg_retire: stall=%b halted=%b want 0/0", bus.stall, bus.halted);
        end
        adv();
        bus.is_debug = 1'b0; bus.pc = 64'h104;
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.halt_cause !== 3'd1 || bus.halt_pc !== 64'h100) begin
            n_bad++; $display("FAIL dbg_halt: halted=%b cause=%0d hpc=%h want 1/1/100",
                              bus.halted, bus.halt_cause, bus.halt_pc);
        end
        bus.is_debug = 1'b1;   // ignored while halted
        adv();
        bus.is_debug = 1'b0;
        bus.step_mode = 1'b1;
        press_pulse();
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.halt_cause !== 3'd1) begin
            n_bad++; $display("FAIL dbg_ignore_in_halt: halted=%b cause=%0d want 1/1",
                              bus.halted, bus.halt_cause);
        end
        adv();
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.halted !== 1'b0 || bus.halt_cause !== 3'd0) begin
            n_bad++; $display("FAIL step_cycle: stall=%b halted=%b cause=%0d want 0/0/0",
                              bus.stall, bus.halted, bus.halt_cause);
        end
        adv();
        bus.pc = 64'h108;
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.halt_cause !== 3'd3 || bus.halt_pc !== 64'h108 || bus.stall !== 1'b1) begin
            n_bad++; $display("FAIL step_halt: halted=%b cause=%0d hpc=%h stall=%b want 1/3/108/1",
                              bus.halted, bus.halt_cause, bus.halt_pc, bus.stall);
        end
        adv();
        release_wait();
        bus.step_mode = 1'b0;
        press_pulse();
        adv();
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b0 || bus.stall !== 1'b0) begin
            n_bad++; $display("FAIL step_resume: halted=%b stall=%b want 0/0", bus.halted, bus.stall);
        end
        adv();
        release_wait();
    endtask

    task automatic test_debounce();
        bit seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            bus.continue_key = seq[k];
            bus.pc = 64'h500 + 64'(4 * k);
            @(negedge clk);
            n_cmp++;
            if (bus.halted !== 1'b0 || bus.stall !== 1'b0) begin
                n_bad++; $display("FAIL deb_early k=%0d: halted=%b stall=%b want 0/0",
                                  k, bus.halted, bus.stall);
            end
            adv();
        end
        bus.pc = 64'h520;   // press pulse is live in this cycle
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b0 || bus.stall !== 1'b0) begin
            n_bad++; $display("FAIL deb_pulse_cycle: halted=%b stall=%b want 0/0", bus.halted, bus.stall);
        end
        adv();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.halted !== 1'b1 || bus.halt_cause !== 3'd4 || bus.halt_pc !== 64'h524) begin
                n_bad++; $display("FAIL deb_ext_halt k=%0d: halted=%b cause=%0d hpc=%h want 1/4/524",
                                  k, bus.halted, bus.halt_cause, bus.halt_pc);
            end
            adv();
        end
        release_wait();
        bus.step_mode = 1'b0;
        press_pulse();
        adv();
        release_wait();
    endtask

    task automatic test_bp_vs_debug();
        bus.bp_wr_en = 1'b1; bus.bp_idx = 2'd2; bus.bp_addr = 64'h200; bus.bp_en = 1'b1;
        bus.pc = 64'h1F8;
        adv();
        bus.bp_wr_en = 1'b0;
        bus.pc = 64'h1FC;
        adv();
        bus.pc = 64'h200; bus.is_debug = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b1) begin
            n_bad++; $display("FAIL bpdbg_stall: got %b want 1", bus.stall);
        end
        adv();
        bus.is_debug = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.halt_cause !== 3'd2 || bus.halt_pc !== 64'h200) begin
            n_bad++; $display("FAIL bpdbg_cause: halted=%b cause=%0d hpc=%h want 1/2/200",
                              bus.halted, bus.halt_cause, bus.halt_pc);
        end
        adv();
        press_pulse();
        adv();
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.halted !== 1'b0) begin
            n_bad++; $display("FAIL bpdbg_resume: stall=%b halted=%b want 0/0", bus.stall, bus.halted);
        end
        adv();
        bus.pc = 64'h204;
        release_wait();
    endtask

    task automatic test_idx_ignore();
        bus.bp_wr_en = 1'b1; bus.bp_idx = 2'd3; bus.bp_addr = 64'h300; bus.bp_en = 1'b1;
        bus.pc = 64'h2F0;
        adv();
        bus.bp_wr_en = 1'b0;
        bus.pc = 64'h300;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_bad++; $display("FAIL idx_out_of_range: stall=%b want 0", bus.stall);
        end
        adv();
        // Same-cycle write must not affect the compare; low address bits ignored
        bus.bp_wr_en = 1'b1; bus.bp_idx = 2'd0; bus.bp_addr = 64'h303; bus.bp_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_bad++; $display("FAIL bp_same_cycle_old: stall=%b want 0", bus.stall);
        end
        adv();
        bus.bp_wr_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b1) begin
            n_bad++; $display("FAIL bp_next_cycle_new: stall=%b want 1", bus.stall);
        end
        adv();
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.halt_cause !== 3'd2 || bus.halt_pc !== 64'h300) begin
            n_bad++; $display("FAIL bp_low_bits: halted=%b cause=%0d hpc=%h want 1/2/300",
                              bus.halted, bus.halt_cause, bus.halt_pc);
        end
        adv();
        bus.bp_wr_en = 1'b1; bus.bp_idx = 2'd0; bus.bp_en = 1'b0;
        adv();
        bus.bp_wr_en = 1'b0;
        press_pulse();
        adv();
        adv();
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.halted !== 1'b0) begin
            n_bad++; $display("FAIL bp_disabled: stall=%b halted=%b want 0/0", bus.stall, bus.halted);
        end
        adv();
        release_wait();
    endtask

    task automatic test_reset_in_step();
        bus.pc = 64'h600; bus.is_debug = 1'b1;
        adv();
        bus.is_debug = 1'b0; bus.pc = 64'h604; bus.step_mode = 1'b1;
        press_pulse();
        adv();
        rst = 1'b1;   // asserted during the STEP cycle
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b0 || bus.stall !== 1'b0) begin
            n_bad++; $display("FAIL rst_step_in_step: halted=%b stall=%b want 0/0", bus.halted, bus.stall);
        end
        adv();
        rst = 1'b0; bus.step_mode = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.halted !== 1'b0 || bus.halt_cause !== 3'd0 || bus.halt_pc !== 64'd0) begin
            n_bad++; $display("FAIL rst_step_state: stall=%b halted=%b cause=%0d hpc=%h want 0/0/0/0",
                              bus.stall, bus.halted, bus.halt_cause, bus.halt_pc);
        end
        adv();
        bus.pc = 64'h40;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_bad++; $display("FAIL rst_bp1_cleared: stall=%b want 0", bus.stall);
        end
        adv();
        bus.pc = 64'h200;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_bad++; $display("FAIL rst_bp2_cleared: stall=%b want 0", bus.stall);
        end
        adv();
        release_wait();
    endtask

    task automatic test_random();
        bit last_stall = 1'b0;
        rst = 1'b1;
        adv();
        rst = 1'b0;
        bus.pc = 64'h1000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.bp_wr_en = ($urandom_range(0, 19) == 0);
            bus.bp_idx   = 2'($urandom_range(0, 3));
            bus.bp_addr  = 64'h1000 + 64'(4 * $urandom_range(0, 15)) + 64'($urandom_range(0, 3));
            bus.bp_en    = 1'($urandom_range(0, 1));
            bus.is_debug = ($urandom_range(0, 29) == 0);
            bus.step_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) bus.continue_key = ~bus.continue_key;
            if (!last_stall) begin
                if ($urandom_range(0, 7) == 0) bus.pc = 64'h1000 + 64'(4 * $urandom_range(0, 15));
                else if (bus.pc >= 64'h103C) bus.pc = 64'h1000;
                else bus.pc = bus.pc + 64'd4;
            end
            @(negedge clk);
            n_cmp++;
            if (bus.stall !== m_stall()) begin
                n_bad++; $display("FAIL rnd_stall cyc=%0d: got %b want %b", cyc, bus.stall, m_stall());
            end
            n_cmp++;
            if (bus.halted !== (m_mode == 1)) begin
                n_bad++; $display("FAIL rnd_halted cyc=%0d: got %b want %b", cyc, bus.halted, (m_mode == 1));
            end
            n_cmp++;
            if (bus.halt_cause !== m_cause) begin
                n_bad++; $display("FAIL rnd_cause cyc=%0d: got %0d want %0d", cyc, bus.halt_cause, m_cause);
            end
            n_cmp++;
            if (bus.halt_pc !== m_hpc) begin
                n_bad++; $display("FAIL rnd_halt_pc cyc=%0d: got %h want %h", cyc, bus.halt_pc, m_hpc);
            end
            last_stall = m_stall();
            adv();
        end
    endtask

    initial begin
        bus.pc = 64'd0; bus.is_debug = 1'b0; bus.continue_key = 1'b0; bus.step_mode = 1'b0;
        bus.bp_wr_en = 1'b0; bus.bp_idx = '0; bus.bp_addr = 64'd0; bus.bp_en = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin m_bpa[i] = 64'd0; m_bpe[i] = 1'b0; end
        #1;
        test_reset();
        test_breakpoint();
        test_resume_skip();
        test_debug_step();
        test_debounce();
        test_bp_vs_debug();
        test_idx_ignore();
        test_reset_in_step();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dbg_halt_unit
`default_nettype wire
